// File: rtl/spi_slave_ram_param_if.sv
// spi_slave_ram_param_if: SPI bus bundle (SS_n, MOSI from master; MISO, frame_err, busy from slave) with master/slave modports
interface spi_slave_ram_param_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic frame_err;
  logic busy;
  modport master (output SS_n, MOSI, input MISO, frame_err, busy);
  modport slave (input SS_n, MOSI, output MISO, frame_err, busy);
endinterface

// File: rtl/spi_slave_ram_param.sv
// spi_slave_ram_param: SPI slave with parametrised RAM (ports clk, rst, bus.slave: SS_n/MOSI in, MISO/frame_err/busy out); define SPI_RAM_BURST_EN for burst auto-increment
module spi_slave_ram_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 256,
  parameter string MEM_INIT = ""
) (
  input logic clk,
  input logic rst,
  spi_slave_ram_param_if.slave bus
);
  localparam int ADDR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int SR_W = DATA_W > ADDR_W ? DATA_W : ADDR_W;
  localparam int CW = $clog2(SR_W + 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
  typedef enum logic [2:0] {IDLE, CMD, OP, PAYLOAD, EXEC, TX, DONE} state_t;
  state_t state, state_n;
  logic [1:0] op, op_n;
  logic [SR_W-1:0] sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n, rd_addr, rd_addr_n;
  logic [DATA_W-1:0] rd_q, rd_q_n;
  logic miso, miso_n, frame_err, err_n, cont, cont_n, we;
  logic [DATA_W-1:0] mem [DEPTH];
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction
`ifdef SPI_RAM_BURST_EN
  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
    return (32'(a) >= DEPTH - 1) ? '0 : a + ADDR_W'(1);
  endfunction
`endif
  always_comb begin
    state_n = state;
    op_n = op;
    sr_n = sr;
    cnt_n = cnt;
    wr_addr_n = wr_addr;
    rd_addr_n = rd_addr;
    rd_q_n = rd_q;
    cont_n = cont;
    miso_n = 1'b0;
    err_n = 1'b0;
    we = 1'b0;
    case (state)
      IDLE: if (!bus.SS_n) begin
        state_n = CMD;
        cont_n = 1'b0;
      end
      CMD: begin
        state_n = bus.SS_n ? IDLE : OP;
        err_n = bus.SS_n;
        op_n[1] = bus.MOSI;
      end
      OP: begin
        state_n = bus.SS_n ? IDLE : (op[1] && bus.MOSI) ? EXEC : PAYLOAD;
        err_n = bus.SS_n;
        op_n[0] = bus.MOSI;
        cnt_n = '0;
      end
      // a clean stop at the start of a burst word (cont, nothing shifted yet) is not an error
      PAYLOAD: if (bus.SS_n) begin
        state_n = IDLE;
        err_n = !(cont && cnt == '0);
      end else begin
        sr_n = {sr[SR_W-2:0], bus.MOSI};
        cnt_n = cnt + CW'(1);
        state_n = (cnt == (op[0] ? D_LAST : A_LAST)) ? EXEC : PAYLOAD;
      end
      EXEC: begin
        state_n = DONE;
        cnt_n = '0;
        case (op)
          2'b00: wr_addr_n = sr[ADDR_W-1:0];
          2'b01: begin
            we = in_range(wr_addr);
`ifdef SPI_RAM_BURST_EN
            wr_addr_n = inc(wr_addr);
            cont_n = 1'b1;
            state_n = bus.SS_n ? DONE : PAYLOAD;
`endif
          end
          2'b10: rd_addr_n = sr[ADDR_W-1:0];
          default: begin
            rd_q_n = in_range(rd_addr) ? mem[rd_addr] : '0;
            state_n = TX;
          end
        endcase
      end
      TX: if (bus.SS_n) begin
        state_n = IDLE;
        err_n = !(cont && cnt == '0);
      end else begin
        miso_n = rd_q[DATA_W-1];
        rd_q_n = rd_q << 1;
        cnt_n = cnt + CW'(1);
        if (cnt == D_LAST) begin
`ifdef SPI_RAM_BURST_EN
          rd_addr_n = inc(rd_addr);
          cont_n = 1'b1;
          state_n = EXEC;
`else
          state_n = DONE;
`endif
        end
      end
      DONE: state_n = bus.SS_n ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      sr <= '0;
      cnt <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
      rd_q <= '0;
      miso <= 1'b0;
      frame_err <= 1'b0;
      cont <= 1'b0;
    end else begin
      state <= state_n;
      op <= op_n;
      sr <= sr_n;
      cnt <= cnt_n;
      wr_addr <= wr_addr_n;
      rd_addr <= rd_addr_n;
      rd_q <= rd_q_n;
      miso <= miso_n;
      frame_err <= err_n;
      cont <= cont_n;
    end
  end
  always_ff @(posedge clk) if (!rst && we) mem[wr_addr] <= sr[DATA_W-1:0];
  assign bus.MISO = miso;
  assign bus.frame_err = frame_err;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_spi_slave_ram_param.sv
// tb_spi_slave_ram_param: directed self-checking bench for spi_slave_ram_param (DEPTH 256 and DEPTH 200 instances)
module tb_spi_slave_ram_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit sel = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q, q2;
  logic pre, post, miso_sel;
  spi_slave_ram_param_if a ();
  spi_slave_ram_param_if b ();
  spi_slave_ram_param #(.DATA_W(8), .DEPTH(256)) dut (.clk(clk), .rst(rst), .bus(a.slave));
  spi_slave_ram_param #(.DATA_W(8), .DEPTH(200)) dut2 (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  assign miso_sel = sel ? b.MISO : a.MISO;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic step(input logic ss, input logic mosi);
    if (sel) begin
      b.SS_n = ss;
      b.MOSI = mosi;
    end else begin
      a.SS_n = ss;
      a.MOSI = mosi;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [1:0] op, input logic [7:0] pl);
    step(1'b0, 1'b0);
    step(1'b0, op[1]);
    step(1'b0, op[0]);
    for (int i = 7; i >= 0; i--) step(1'b0, pl[i]);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask
  task automatic rd_data(output logic [7:0] d, output logic p0, output logic p1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    p0 = miso_sel;
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, 1'b0);
      d[i] = miso_sel;
    end
    step(1'b0, 1'b0);
    p1 = miso_sel;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask
  task automatic test_reset();
    a.SS_n = 1'b0; a.MOSI = 1'b1; b.SS_n = 1'b0; b.MOSI = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_chk++; if (a.MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", a.MISO); end
    n_chk++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", a.busy); end
    n_chk++; if (a.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", a.frame_err); end
    n_chk++; if (b.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy2 got %b want 0", b.busy); end
    a.SS_n = 1'b1; b.SS_n = 1'b1; a.MOSI = 1'b0; b.MOSI = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_write();
    logic [7:0] d = 8'hAA;
    sel = 1'b0;
    frame(2'b00, 8'h1F);
    n_chk++; if (dut.wr_addr !== 8'h1F) begin n_fail++; $display("FAIL wr_addr got %h want 1f", dut.wr_addr); end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) step(1'b0, d[i]);
    n_chk++; if (a.busy !== 1'b1) begin n_fail++; $display("FAIL write_busy got %b want 1", a.busy); end
    step(1'b0, 1'b0);
    n_chk++; if (dut.mem[8'h1F] !== 8'hAA) begin n_fail++; $display("FAIL write_commit got %h want aa", dut.mem[8'h1F]); end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_chk++; if (a.frame_err !== 1'b0) begin n_fail++; $display("FAIL write_no_err got %b want 0", a.frame_err); end
    n_chk++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL write_idle got %b want 0", a.busy); end
  endtask
  task automatic test_read();
    sel = 1'b0;
    frame(2'b10, 8'h1F);
    rd_data(q, pre, post);
    n_chk++; if (pre !== 1'b0) begin n_fail++; $display("FAIL read_pre got %b want 0", pre); end
    n_chk++; if (q !== 8'hAA) begin n_fail++; $display("FAIL read_data got %h want aa", q); end
    n_chk++; if (post !== 1'b0) begin n_fail++; $display("FAIL read_post got %b want 0", post); end
  endtask
  task automatic test_abort();
    sel = 1'b0;
    frame(2'b00, 8'h1F);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    n_chk++; if (a.frame_err !== 1'b1) begin n_fail++; $display("FAIL abort_err got %b want 1", a.frame_err); end
    n_chk++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", a.busy); end
    step(1'b1, 1'b0);
    n_chk++; if (a.frame_err !== 1'b0) begin n_fail++; $display("FAIL abort_pulse got %b want 0", a.frame_err); end
    n_chk++; if (dut.mem[8'h1F] !== 8'hAA) begin n_fail++; $display("FAIL abort_mem got %h want aa", dut.mem[8'h1F]); end
    n_chk++; if (dut.wr_addr !== 8'h1F) begin n_fail++; $display("FAIL abort_wr_addr got %h want 1f", dut.wr_addr); end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_chk++; if (a.frame_err !== 1'b1) begin n_fail++; $display("FAIL abort_cmd_err got %b want 1", a.frame_err); end
    step(1'b1, 1'b0);
    frame(2'b10, 8'h1F);
    step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    n_chk++; if (a.MISO !== 1'b1) begin n_fail++; $display("FAIL abort_tx_bit got %b want 1", a.MISO); end
    step(1'b1, 1'b0);
    n_chk++; if (a.frame_err !== 1'b1) begin n_fail++; $display("FAIL abort_tx_err got %b want 1", a.frame_err); end
    n_chk++; if (a.MISO !== 1'b0) begin n_fail++; $display("FAIL abort_tx_miso got %b want 0", a.MISO); end
    step(1'b1, 1'b0);
    rd_data(q, pre, post);
    n_chk++; if (q !== 8'hAA) begin n_fail++; $display("FAIL abort_reread got %h want aa", q); end
  endtask
  task automatic test_rst_priority();
    logic [7:0] d = 8'h77;
    sel = 1'b0;
    frame(2'b00, 8'h05);
    frame(2'b01, 8'h3C);
    frame(2'b00, 8'h05);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) step(1'b0, d[i]);
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    n_chk++; if (dut.mem[8'h05] !== 8'h3C) begin n_fail++; $display("FAIL rst_blocks_write got %h want 3c", dut.mem[8'h05]); end
    n_chk++; if (dut.wr_addr !== 8'h00) begin n_fail++; $display("FAIL rst_wr_addr got %h want 00", dut.wr_addr); end
    n_chk++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", a.busy); end
    step(1'b1, 1'b0);
    frame(2'b10, 8'h05);
    rd_data(q, pre, post);
    n_chk++; if (q !== 8'h3C) begin n_fail++; $display("FAIL rst_keeps_ram got %h want 3c", q); end
  endtask
`ifdef SPI_RAM_BURST_EN
  task automatic test_burst();
    logic [7:0] d1 = 8'h11;
    logic [7:0] d2 = 8'h22;
    sel = 1'b0;
    frame(2'b00, 8'hFF);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) step(1'b0, d1[i]);
    step(1'b0, 1'b0);
    n_chk++; if (dut.mem[8'hFF] !== 8'h11) begin n_fail++; $display("FAIL burst_w0 got %h want 11", dut.mem[8'hFF]); end
    for (int i = 7; i >= 0; i--) step(1'b0, d2[i]);
    step(1'b0, 1'b0);
    n_chk++; if (dut.mem[8'h00] !== 8'h22) begin n_fail++; $display("FAIL burst_w1 got %h want 22", dut.mem[8'h00]); end
    n_chk++; if (dut.wr_addr !== 8'h01) begin n_fail++; $display("FAIL burst_wr_addr got %h want 01", dut.wr_addr); end
    step(1'b1, 1'b0);
    n_chk++; if (a.frame_err !== 1'b0) begin n_fail++; $display("FAIL burst_w_end_err got %b want 0", a.frame_err); end
    step(1'b1, 1'b0);
    frame(2'b10, 8'hFF);
    step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin step(1'b0, 1'b0); q[i] = a.MISO; end
    step(1'b0, 1'b0);
    n_chk++; if (a.MISO !== 1'b0) begin n_fail++; $display("FAIL burst_gap got %b want 0", a.MISO); end
    for (int i = 7; i >= 0; i--) begin step(1'b0, 1'b0); q2[i] = a.MISO; end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_chk++; if (q !== 8'h11) begin n_fail++; $display("FAIL burst_r0 got %h want 11", q); end
    n_chk++; if (q2 !== 8'h22) begin n_fail++; $display("FAIL burst_r1 got %h want 22", q2); end
    n_chk++; if (a.frame_err !== 1'b0) begin n_fail++; $display("FAIL burst_r_end_err got %b want 0", a.frame_err); end
    n_chk++; if (dut.rd_addr !== 8'h01) begin n_fail++; $display("FAIL burst_rd_addr got %h want 01", dut.rd_addr); end
    step(1'b1, 1'b0);
  endtask
`else
  task automatic test_single();
    logic [7:0] d1 = 8'h12;
    logic [7:0] d2 = 8'h34;
    sel = 1'b0;
    frame(2'b00, 8'h41);
    frame(2'b01, 8'h00);
    frame(2'b00, 8'h40);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) step(1'b0, d1[i]);
    step(1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) step(1'b0, d2[i]);
    n_chk++; if (a.busy !== 1'b1) begin n_fail++; $display("FAIL single_done_busy got %b want 1", a.busy); end
    step(1'b1, 1'b0);
    n_chk++; if (a.frame_err !== 1'b0) begin n_fail++; $display("FAIL single_done_err got %b want 0", a.frame_err); end
    step(1'b1, 1'b0);
    n_chk++; if (dut.mem[8'h40] !== 8'h12) begin n_fail++; $display("FAIL single_w0 got %h want 12", dut.mem[8'h40]); end
    n_chk++; if (dut.mem[8'h41] !== 8'h00) begin n_fail++; $display("FAIL single_no_w1 got %h want 00", dut.mem[8'h41]); end
    n_chk++; if (dut.wr_addr !== 8'h40) begin n_fail++; $display("FAIL single_wr_addr got %h want 40", dut.wr_addr); end
  endtask
`endif
  task automatic test_range();
    sel = 1'b1;
    step(1'b1, 1'b0);
    frame(2'b01, 8'h81);
    rd_data(q, pre, post);
    n_chk++; if (q !== 8'h81) begin n_fail++; $display("FAIL range_default_rd_addr got %h want 81", q); end
    frame(2'b00, 8'hC7);
    frame(2'b01, 8'h5A);
    frame(2'b00, 8'hC8);
    frame(2'b01, 8'h55);
    n_chk++; if (dut2.mem[0] !== 8'h81) begin n_fail++; $display("FAIL range_mem0 got %h want 81", dut2.mem[0]); end
    frame(2'b10, 8'hC7);
    rd_data(q, pre, post);
    n_chk++; if (q !== 8'h5A) begin n_fail++; $display("FAIL range_last_word got %h want 5a", q); end
    frame(2'b10, 8'hC8);
    rd_data(q, pre, post);
    n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL range_oob_read got %h want 00", q); end
    sel = 1'b0;
  endtask
  initial begin
    a.SS_n = 1'b1; a.MOSI = 1'b0; b.SS_n = 1'b1; b.MOSI = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_rst_priority();
`ifdef SPI_RAM_BURST_EN
    test_burst();
`else
    test_single();
`endif
    test_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
